ifu_fetch: RTL and testbench

- Instruction fetch stage, directly upstream of the instruction memory and downstream-facing to decode.
- Owns the PC register and drives the fetch address to instruction memory each cycle.
- Memory latches its read on the negedge, so the instruction arrives in the same cycle.
- Fetched {pc, inst} pairs are buffered in a small FIFO and handed to decode over valid/ready; branch/jump redirects flush the buffer and restart fetch.

---
 rtl/ifu_fetch.sv | 150 +++++++++++++++
 tb/tb_ifu_fetch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage.
//   Owns the PC, drives the fetch address to instruction memory every cycle,
//   and captures the same-cycle instruction into a small FIFO that decode
//   drains over a valid/ready handshake. A redirect flushes the FIFO and
//   restarts fetch at redirect_pc.
//
// Ports:
//   clk, rst             clock (posedge) / asynchronous active-high reset
//   imem_addr (out)      fetch address, equals the PC register
//   imem_inst (in)       instruction for imem_addr, valid in the same cycle
//   dec_valid (out)      FIFO head valid
//   dec_ready (in)       decode accepts the head
//   dec_pc, dec_inst     head entry (zero while the FIFO is empty)
//   redirect (in)        flush the FIFO and restart fetch
//   redirect_pc (in)     new fetch PC
//   fetch_cnt (out)      number of instructions pushed into the FIFO (wraps)
//   misalign (out)       sticky misaligned-redirect flag
//
// Build option:
//   IFU_MISALIGN_CHK_EN  when defined, a redirect to a non-word-aligned PC
//                        sets misalign and halts fetch until reset. When
//                        undefined, redirect_pc[1:0] is forced to zero and
//                        misalign is tied low.
module ifu_fetch #(
  parameter int              XLEN   = 32,
  parameter int              INST_W = 32,
  parameter int              DEPTH  = 2,
  parameter logic [XLEN-1:0] PC_RST = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [XLEN-1:0]   dec_pc,
  output logic [INST_W-1:0] dec_inst,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic [31:0]       fetch_cnt,
  output logic              misalign
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     fcnt_q, fcnt_d;
  logic            halted;
  logic            push, pop;

  // Entry storage is data only; validity is carried by cnt_q.
  logic [XLEN-1:0]   buf_pc   [DEPTH];
  logic [INST_W-1:0] buf_inst [DEPTH];

`ifdef IFU_MISALIGN_CHK_EN
  logic halt_q, halt_d;

  always_comb begin
    halt_d = halt_q;
    if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  assign halted   = halt_q;
  assign misalign = halt_q;
`else
  assign halted   = 1'b0;
  assign misalign = 1'b0;
`endif

  assign dec_valid = (cnt_q != '0);
  // A redirect discards the head, so decode must not see it consumed.
  assign pop       = dec_valid & dec_ready & ~redirect;
  // Full + pop frees a slot in the same cycle, so fetch keeps streaming.
  assign push      = ~redirect & ~halted & ((cnt_q < CW'(DEPTH)) | pop);

  assign imem_addr = pc_q;
  assign fetch_cnt = fcnt_q;
  assign dec_pc    = dec_valid ? buf_pc[rd_q]   : '0;
  assign dec_inst  = dec_valid ? buf_inst[rd_q] : '0;

  always_comb begin
    pc_d   = pc_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    fcnt_d = fcnt_q;
    if (redirect) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
`ifdef IFU_MISALIGN_CHK_EN
      pc_d  = redirect_pc;
`else
      pc_d  = redirect_pc & WORD_MASK;
`endif
    end else begin
      if (push) begin
        wr_d   = wr_q + PW'(1);
        pc_d   = pc_q + XLEN'(4);
        fcnt_d = fcnt_q + 32'd1;
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= PC_RST;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      fcnt_q <= '0;
    end else begin
      pc_q   <= pc_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_q]   <= pc_q;
      buf_inst[wr_q] <= imem_inst;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  localparam logic [31:0] PC_RST = 32'h8000_0000;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_inst;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_pc, dec_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_cnt;
  logic        misalign;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Instruction memory: word i holds 0x11*(i+1), indexed by addr[7:2].
  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] idx;
    idx = {26'b0, a[7:2]};
    return 32'h11 * (idx + 32'd1);
  endfunction

  assign imem_inst = memf(imem_addr);

  ifu_fetch #(.XLEN(32), .INST_W(32), .DEPTH(DEPTH), .PC_RST(PC_RST)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .dec_inst(dec_inst), .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_cnt(fetch_cnt), .misalign(misalign)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {pc, inst} entries plus the fetch PC.
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc;
  logic [31:0] mcnt;
  logic        mmis;

  task automatic mstep(input logic r, input logic rdy, input logic rd, input logic [31:0] rp);
    ent_t e;
    bit   pop, push;
    if (r) begin
      mq.delete(); mpc = PC_RST; mcnt = 0; mmis = 0;
      return;
    end
    pop  = (mq.size() != 0) && rdy && !rd;
    push = !rd && !mmis && ((mq.size() < DEPTH) || pop);
    if (rd) begin
      mq.delete();
`ifdef IFU_MISALIGN_CHK_EN
      if (rp[1:0] != 2'b00) mmis = 1'b1;
      mpc = rp;
`else
      mpc = {rp[31:2], 2'b00};
`endif
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc = mpc; e.inst = memf(mpc);
        mq.push_back(e);
        mpc  = mpc + 32'd4;
        mcnt = mcnt + 32'd1;
      end
    end
  endtask

  task automatic mchk();
    chk("rnd_valid", {63'b0, dec_valid}, {63'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("rnd_pc", {32'b0, dec_pc}, {32'b0, mq[0].pc});
      chk("rnd_inst", {32'b0, dec_inst}, {32'b0, mq[0].inst});
    end
    chk("rnd_cnt", {32'b0, fetch_cnt}, {32'b0, mcnt});
    chk("rnd_addr", {32'b0, imem_addr}, {32'b0, mpc});
    chk("rnd_mis", {63'b0, misalign}, {63'b0, mmis});
  endtask

  // Drive one cycle from a negedge, advance model, land on next negedge.
  task automatic cycle(input logic r, input logic rdy, input logic rd, input logic [31:0] rp);
    rst = r; dec_ready = rdy; redirect = rd; redirect_pc = rp;
    mstep(r, rdy, rd, rp);
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic r, rdy, rd; logic [31:0] rp;
    logic ev; logic [31:0] epc, einst, ecnt, eaddr; logic emis;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic rdy, input logic rd, input logic [31:0] rp,
                     input logic ev, input logic [31:0] epc, input logic [31:0] einst,
                     input logic [31:0] ecnt, input logic [31:0] eaddr, input logic emis);
    vec_t v;
    v.r = r; v.rdy = rdy; v.rd = rd; v.rp = rp; v.ev = ev; v.epc = epc;
    v.einst = einst; v.ecnt = ecnt; v.eaddr = eaddr; v.emis = emis;
    tbl.push_back(v);
  endtask

  initial begin
    logic r, rdy, rd;
    logic [31:0] rp;
    rst = 1'b1; dec_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mstep(1'b1, 1'b0, 1'b0, '0);
    #1;
    chk("rst_valid", {63'b0, dec_valid}, 64'd0);
    chk("rst_pc", {32'b0, dec_pc}, 64'd0);
    chk("rst_inst", {32'b0, dec_inst}, 64'd0);
    chk("rst_cnt", {32'b0, fetch_cnt}, 64'd0);
    chk("rst_addr", {32'b0, imem_addr}, {32'b0, PC_RST});
    chk("rst_mis", {63'b0, misalign}, 64'd0);
    @(negedge clk);

    // Streaming with ready=1
    add(0,1,0,0, 1,32'h8000_0000,32'h11,1,32'h8000_0004,0);
    add(0,1,0,0, 1,32'h8000_0004,32'h22,2,32'h8000_0008,0);
    add(0,1,0,0, 1,32'h8000_0008,32'h33,3,32'h8000_000C,0);
    // Reset, then stall with ready=0
    add(1,0,0,0, 0,0,0,0,32'h8000_0000,0);
    add(0,0,0,0, 1,32'h8000_0000,32'h11,1,32'h8000_0004,0);
    add(0,0,0,0, 1,32'h8000_0000,32'h11,2,32'h8000_0008,0);
    add(0,0,0,0, 1,32'h8000_0000,32'h11,2,32'h8000_0008,0);
    add(0,0,0,0, 1,32'h8000_0000,32'h11,2,32'h8000_0008,0);
    add(0,0,0,0, 1,32'h8000_0000,32'h11,2,32'h8000_0008,0);
    // Drain while full: push+pop in same cycle
    add(0,1,0,0, 1,32'h8000_0004,32'h22,3,32'h8000_000C,0);
    add(0,1,0,0, 1,32'h8000_0008,32'h33,4,32'h8000_0010,0);
    add(0,1,0,0, 1,32'h8000_000C,32'h44,5,32'h8000_0014,0);
    // Redirect with 2 entries buffered and ready=1
    add(0,1,1,32'h8000_0040, 0,0,0,5,32'h8000_0040,0);
    add(0,1,0,0, 1,32'h8000_0040,32'h121,6,32'h8000_0044,0);
    // Misaligned redirect
`ifdef IFU_MISALIGN_CHK_EN
    add(0,1,1,32'h8000_0042, 0,0,0,6,32'h8000_0042,1);
    add(0,1,0,0, 0,0,0,6,32'h8000_0042,1);
    add(0,0,0,0, 0,0,0,6,32'h8000_0042,1);
    add(0,0,0,0, 0,0,0,6,32'h8000_0042,1);
`else
    add(0,1,1,32'h8000_0042, 0,0,0,6,32'h8000_0040,0);
    add(0,1,0,0, 1,32'h8000_0040,32'h121,7,32'h8000_0044,0);
    add(0,0,0,0, 1,32'h8000_0040,32'h121,8,32'h8000_0048,0);
    add(0,0,0,0, 1,32'h8000_0040,32'h121,8,32'h8000_0048,0);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].rdy, tbl[i].rd, tbl[i].rp);
      chk($sformatf("t%0d_valid", i), {63'b0, dec_valid}, {63'b0, tbl[i].ev});
      if (tbl[i].ev || tbl[i].r) begin
        chk($sformatf("t%0d_pc", i), {32'b0, dec_pc}, {32'b0, tbl[i].epc});
        chk($sformatf("t%0d_inst", i), {32'b0, dec_inst}, {32'b0, tbl[i].einst});
      end
      chk($sformatf("t%0d_cnt", i), {32'b0, fetch_cnt}, {32'b0, tbl[i].ecnt});
      chk($sformatf("t%0d_addr", i), {32'b0, imem_addr}, {32'b0, tbl[i].eaddr});
      chk($sformatf("t%0d_mis", i), {63'b0, misalign}, {63'b0, tbl[i].emis});
    end

    // Asynchronous reset mid-stream, checked before the next clock edge
    #2;
    rst = 1'b1;
    mstep(1'b1, 1'b0, 1'b0, '0);
    #1;
    chk("async_valid", {63'b0, dec_valid}, 64'd0);
    chk("async_cnt", {32'b0, fetch_cnt}, 64'd0);
    chk("async_addr", {32'b0, imem_addr}, {32'b0, PC_RST});
    chk("async_mis", {63'b0, misalign}, 64'd0);
    @(negedge clk);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("restart_valid", {63'b0, dec_valid}, 64'd1);
    chk("restart_pc", {32'b0, dec_pc}, {32'b0, PC_RST});
    chk("restart_inst", {32'b0, dec_inst}, 64'h11);
    chk("restart_cnt", {32'b0, fetch_cnt}, 64'd1);

    // Randomized traffic against the queue model
    for (int i = 0; i < 1500; i++) begin
      r   = (i % 300 == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 19) == 0);
      rp  = PC_RST + ($urandom_range(0, 63) << 2);
      if ($urandom_range(0, 24) == 0) rp = rp + $urandom_range(1, 3);
      cycle(r, rdy, rd, rp);
      mchk();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
